echo_fifo_param: RTL and testbench
==================================

# echo_fifo_param

Parametrised echo server: accepts `echoReq` values into an internal circular buffer of `DEPTH` entries and width `WIDTH`. It returns each value, transformed by a runtime-selectable mode, on the `ind$echo` indication method. It adds a deeper buffer, a value transform, an occupancy output and a delivered-echo counter. It sits between the request-side method interface and the indication proxy in echo-style test designs.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8.
- `DEPTH`, 4: buffer entries; must be a power of 2 and ≥2.
- `CNT_W`, 16: width of the echo counter.
- `CLK` in 1: the single clock; all state changes on its rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `echoReq__ENA` in 1: request enqueue; legal only while `echoReq__RDY`=1.
- `echoReq_v` in WIDTH: request value.
- `echoReq__RDY` out 1: buffer not full.
- `setMode__ENA` in 1: load the transform mode.
- `setMode_m` in 2: new mode.
- `setMode__RDY` out 1: constant 1.
- `ind$echo__ENA` out 1: indication fires this cycle.
- `ind$echo$v` out WIDTH: indication value.
- `ind$echo__RDY` in 1: indication sink ready.
- `level` out clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `count` out CNT_W: number of echoes delivered, modulo 2^CNT_W.

## Operation
- Storage: `DEPTH`×`WIDTH` memory. The write pointer `wp` and read pointer `rp` are each clog2(DEPTH) bits and wrap naturally. `level` is a separate register. Memory contents are not reset.
- Enqueue: when `echoReq__ENA`=1, write `xf(mode, echoReq_v)` at `wp`, then `wp`++.
- Transform `xf` is applied at enqueue using the mode register value *before* any same-cycle `setMode` update:
  - 0 = pass-through.
  - 1 = `v+1` modulo 2^WIDTH (all-ones wraps to 0).
  - 2 = bitwise invert.
  - 3 = byte reverse (byte 0 ↔ byte WIDTH/8−1).
- Mode register: 2 bits. `setMode__ENA`=1 loads `setMode_m` on the next edge. Entries already buffered keep their stored transform.
- Respond rule: fires automatically.
  - `ind$echo__ENA` = (`level`≠0) & `ind$echo__RDY`, combinational.
  - When `ind$echo__ENA`=1: `ind$echo$v` = mem[`rp`]. At the edge, `rp`++ and `count`++ (wrapping).
  - When `ind$echo__ENA`=0: `ind$echo$v` = 0.
- `echoReq__RDY` = (`level` < DEPTH), a registered-state function with no combinational path from `ind$echo__RDY`. When full, no enqueue is accepted even if a dequeue occurs in the same cycle.
- `level` update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue. This is legal whenever 0<`level`<DEPTH.
- Enqueue while empty: no bypass. The value is first visible the following cycle.
- `echoReq__ENA` while `echoReq__RDY`=0 is a protocol error. The block ignores it: no state change.
- Reset (asynchronous, any time, including mid-stream):
  - `wp`, `rp`, `level`, `count` and `mode` all go to 0.
  - Outputs during and after reset: `ind$echo__ENA`=0, `ind$echo$v`=0, `echoReq__RDY`=1, `level`=0, `count`=0.
  - Buffered data is discarded.

## Timing
- Enqueue-to-indication latency: 1 cycle minimum. A value enqueued at edge N can fire `ind$echo__ENA` in cycle N+1 if `ind$echo__RDY`=1.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained.
- Full-to-ready: a dequeue at edge N makes `echoReq__RDY`=1 in cycle N+1.
- Order is strictly FIFO. Output order equals acceptance order across all mode changes.
- The only combinational paths are `ind$echo__RDY` → `ind$echo__ENA` and `ind$echo__RDY` → `ind$echo$v`.

## Test plan
- Reset, then enqueue 5, 6, 7 with `ind$echo__RDY`=1, mode 0 → `ind$echo` fires 5, 6, 7 on consecutive cycles, each one cycle after its enqueue; `count`=3; `level` returns to 0.
- Hold `ind$echo__RDY`=0 and enqueue 4 values (DEPTH=4) → `level`=4 and `echoReq__RDY`=0. A 5th `echoReq__ENA` is ignored. Raise RDY → exactly the 4 values come out, then `echoReq__RDY` reasserts.
- Set mode 1 and enqueue 0xFFFFFFFF → 0x00000000. Set mode 3 and enqueue 0x11223344 → 0x44332211. Set mode 2 and enqueue 0x0F0F0F0F → 0xF0F0F0F0.
- Same-cycle `setMode(2)` and `echoReq(0x1)` while in mode 0 → output 0x1. The next request 0x1 → 0xFFFFFFFE.
- Random simultaneous enqueue/dequeue at `level`=2 for 1000 cycles with random `ind$echo__RDY` → scoreboard FIFO match, `level` never leaves 0..4, and `count` wraps correctly with CNT_W=4.
- Assert `nRST` low asynchronously mid-stream with `level`=3 → all outputs immediately reach their reset values; after release, no stale value appears on `ind$echo`.

Source files
------------

// File: rtl/echo_fifo_param_if.sv
// Request/indication bundle for the echo server.
//
// Handshake semantics:
//   echoReq:  the producer asserts echoReq__ENA only while echoReq__RDY=1.
//             A value is accepted on any rising edge where both are high.
//             echoReq__RDY depends only on registered state.
//   setMode:  always ready. setMode__ENA loads setMode_m on the edge.
//   ind_echo: the server asserts ind_echo__ENA whenever it holds data and the
//             sink reports ind_echo__RDY=1. The value on ind_echo_v is
//             consumed on that same edge. The sink may not refuse a fired
//             indication.
interface echo_fifo_param_if #(
  parameter int WIDTH = 32
);
  logic             echoReq__ENA;
  logic [WIDTH-1:0] echoReq_v;
  logic             echoReq__RDY;
  logic             setMode__ENA;
  logic [1:0]       setMode_m;
  logic             setMode__RDY;
  logic             ind_echo__ENA;
  logic [WIDTH-1:0] ind_echo_v;
  logic             ind_echo__RDY;

  // Echo server side.
  modport slave (
    input  echoReq__ENA, echoReq_v, setMode__ENA, setMode_m, ind_echo__RDY,
    output echoReq__RDY, setMode__RDY, ind_echo__ENA, ind_echo_v
  );

  // Requester / indication-sink side.
  modport master (
    output echoReq__ENA, echoReq_v, setMode__ENA, setMode_m, ind_echo__RDY,
    input  echoReq__RDY, setMode__RDY, ind_echo__ENA, ind_echo_v
  );
endinterface

// File: rtl/echo_fifo_param.sv
// Parametrised echo server: circular buffer of DEPTH x WIDTH entries.
// Each request is transformed by the current mode at enqueue time. It is
// returned in FIFO order on the indication port whenever the sink is ready.
module echo_fifo_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  echo_fifo_param_if.slave      bus,
  output logic [LW-1:0]         level,
  output logic [CNT_W-1:0]      count
);

  localparam int NB = WIDTH / 8;

  // Value transform applied at enqueue time.
  function automatic logic [WIDTH-1:0] xf(input logic [1:0] m,
                                          input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      2'd0: r = v;
      2'd1: r = v + {{(WIDTH-1){1'b0}}, 1'b1};
      2'd2: r = ~v;
      default: begin
        for (int b = 0; b < NB; b++) begin
          r[b*8 +: 8] = v[(NB-1-b)*8 +: 8];
        end
      end
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;

  logic not_full;
  logic not_empty;
  logic enq;
  logic deq;

  // Accept/fire decisions; readiness comes only from registered occupancy.
  always_comb begin
    not_full  = (level_q < LW'(DEPTH));
    not_empty = (level_q != '0);
    enq       = bus.echoReq__ENA & not_full;
    deq       = not_empty & bus.ind_echo__RDY;
  end

  // Next-state for pointers, occupancy, counter and mode.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (enq) begin
      wp_d = wp_q + AW'(1);
    end
    if (deq) begin
      rp_d    = rp_q + AW'(1);
      count_d = count_q + CNT_W'(1);
    end
    case ({enq, deq})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (bus.setMode__ENA) begin
      mode_d = bus.setMode_m;
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      count_q <= '0;
      mode_q  <= 2'd0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_q[wp_q] <= xf(mode_q, bus.echoReq_v);
    end
  end

  // Output drive; the indication value is zero whenever it does not fire.
  always_comb begin
    bus.echoReq__RDY  = not_full;
    bus.setMode__RDY  = 1'b1;
    bus.ind_echo__ENA = deq;
    bus.ind_echo_v    = deq ? mem_q[rp_q] : '0;
    level             = level_q;
    count             = count_q;
  end

  // Occupancy can never exceed the buffer size.
  property p_level_bound;
    @(posedge CLK) disable iff (!nRST) level_q <= LW'(DEPTH);
  endproperty
  a_level_bound: assert property (p_level_bound);

endmodule

// File: tb/tb_echo_fifo_param.sv
// Self-checking bench for echo_fifo_param (WIDTH=32, DEPTH=4, CNT_W=4).
module tb_echo_fifo_param;

  logic       clk;
  logic       rst_n;
  logic [2:0] level;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  echo_fifo_param_if #(.WIDTH(32)) bus ();

  echo_fifo_param #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) dut (
    .CLK   (clk),
    .nRST  (rst_n),
    .bus   (bus),
    .level (level),
    .count (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic fire, input logic [31:0] v,
                            input logic [2:0] lvl, input logic [3:0] cnt, input logic rrdy);
    check({tag, ".fire"},    32'(bus.ind_echo__ENA), 32'(fire));
    check({tag, ".value"},   bus.ind_echo_v,          v);
    check({tag, ".level"},   32'(level),              32'(lvl));
    check({tag, ".count"},   32'(count),              32'(cnt));
    check({tag, ".req_rdy"}, 32'(bus.echoReq__RDY),   32'(rrdy));
  endtask

  task automatic drive(input logic enq, input logic [31:0] v, input logic set,
                       input logic [1:0] m, input logic rdy);
    bus.echoReq__ENA  = enq;
    bus.echoReq_v     = v;
    bus.setMode__ENA  = set;
    bus.setMode_m     = m;
    bus.ind_echo__RDY = rdy;
  endtask

  // Independent reference transform for 32-bit data.
  function automatic logic [31:0] ref_xf(input logic [1:0] m, input logic [31:0] v);
    case (m)
      2'd0:    return v;
      2'd1:    return v + 32'd1;
      2'd2:    return ~v;
      default: return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        enq;
    logic [31:0] v;
    logic        set;
    logic [1:0]  m;
    logic        rdy;
    logic        exp_fire;
    logic [31:0] exp_v;
    logic [2:0]  exp_level;
    logic [3:0]  exp_count;
    logic        exp_req_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic enq, input logic [31:0] v, input logic set, input logic [1:0] m,
                     input logic rdy, input logic ef, input logic [31:0] ev,
                     input logic [2:0] el, input logic [3:0] ec, input logic er);
    vec_t t;
    t.enq = enq; t.v = v; t.set = set; t.m = m; t.rdy = rdy;
    t.exp_fire = ef; t.exp_v = ev; t.exp_level = el; t.exp_count = ec; t.exp_req_rdy = er;
    vecs.push_back(t);
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [1:0]  m_mode;
  logic [3:0]  m_count;

  initial begin
    logic        enq, rdy, set;
    logic [31:0] v;
    logic [1:0]  m;
    logic        acc, dq;
    int          sz;

    //            enq v             set m  rdy | fire v             lvl cnt rrdy
    // FIFO basics: one cycle latency, back-to-back.
    add(1, 32'd5,        0, 0, 1,   0, 32'd0,        0, 0,  1);
    add(1, 32'd6,        0, 0, 1,   1, 32'd5,        1, 0,  1);
    add(1, 32'd7,        0, 0, 1,   1, 32'd6,        1, 1,  1);
    add(0, 32'd0,        0, 0, 1,   1, 32'd7,        1, 2,  1);
    add(0, 32'd0,        0, 0, 1,   0, 32'd0,        0, 3,  1);
    // Fill to full with sink stalled; extra request ignored.
    add(1, 32'hA0,       0, 0, 0,   0, 32'd0,        0, 3,  1);
    add(1, 32'hA1,       0, 0, 0,   0, 32'd0,        1, 3,  1);
    add(1, 32'hA2,       0, 0, 0,   0, 32'd0,        2, 3,  1);
    add(1, 32'hA3,       0, 0, 0,   0, 32'd0,        3, 3,  1);
    add(1, 32'hB0,       0, 0, 0,   0, 32'd0,        4, 3,  0);
    // Full with dequeue: same-cycle request still refused.
    add(1, 32'hBB,       0, 0, 1,   1, 32'hA0,       4, 3,  0);
    add(0, 32'd0,        0, 0, 1,   1, 32'hA1,       3, 4,  1);
    add(0, 32'd0,        0, 0, 1,   1, 32'hA2,       2, 5,  1);
    add(0, 32'd0,        0, 0, 1,   1, 32'hA3,       1, 6,  1);
    add(0, 32'd0,        0, 0, 1,   0, 32'd0,        0, 7,  1);
    // Transforms.
    add(0, 32'd0,        1, 1, 1,   0, 32'd0,        0, 7,  1);
    add(1, 32'hFFFFFFFF, 0, 0, 1,   0, 32'd0,        0, 7,  1);
    add(0, 32'd0,        1, 3, 1,   1, 32'h00000000, 1, 7,  1);
    add(1, 32'h11223344, 0, 0, 1,   0, 32'd0,        0, 8,  1);
    add(0, 32'd0,        1, 2, 1,   1, 32'h44332211, 1, 8,  1);
    add(1, 32'h0F0F0F0F, 0, 0, 1,   0, 32'd0,        0, 9,  1);
    add(0, 32'd0,        1, 0, 1,   1, 32'hF0F0F0F0, 1, 9,  1);
    // Same-cycle mode change uses the old mode for that request.
    add(1, 32'h1,        1, 2, 1,   0, 32'd0,        0, 10, 1);
    add(1, 32'h1,        0, 0, 1,   1, 32'h1,        1, 10, 1);
    add(0, 32'd0,        0, 0, 1,   1, 32'hFFFFFFFE, 1, 11, 1);
    add(0, 32'd0,        0, 0, 1,   0, 32'd0,        0, 12, 1);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 32'd0, 0, 0, 1);
    #12;
    check_outs("reset", 0, 32'd0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].enq, vecs[i].v, vecs[i].set, vecs[i].m, vecs[i].rdy);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_fire, vecs[i].exp_v,
                 vecs[i].exp_level, vecs[i].exp_count, vecs[i].exp_req_rdy);
    end

    // Random enqueue/dequeue around level 2 against the scoreboard.
    m_mode  = 2'd2;
    m_count = 4'd12;
    for (int c = 0; c < 1000; c++) begin
      sz  = exp_q.size();
      rdy = 1'($urandom_range(0, 1));
      if (sz >= 4)      enq = 1'b0;
      else if (sz < 2)  enq = ($urandom_range(0, 3) != 0);
      else              enq = 1'($urandom_range(0, 1));
      v   = $urandom;
      set = ($urandom_range(0, 7) == 0);
      m   = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      drive(enq, v, set, m, rdy);
      @(negedge clk);
      dq  = (sz != 0) && rdy;
      acc = enq && (sz < 4);
      check_outs("rand", dq, dq ? exp_q[0] : 32'd0, 3'(sz), m_count, sz < 4);
      if (dq) begin
        void'(exp_q.pop_front());
        m_count = m_count + 4'd1;
      end
      if (acc) exp_q.push_back(ref_xf(m_mode, v));
      if (set) m_mode = m;
    end

    // Drain, force mode 0, then stall and load three entries.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      drive(0, 32'd0, 1, 0, 1);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      drive(1, 32'hC0 + 32'(c), 0, 0, 0);
    end
    @(posedge clk);
    #1;
    drive(0, 32'd0, 0, 0, 0);
    @(negedge clk);
    check("pre_reset.level", 32'(level), 32'd3);
    bus.ind_echo__RDY = 1'b1;
    #1;
    check("pre_reset.fire", 32'(bus.ind_echo__ENA), 32'd1);
    check("pre_reset.value", bus.ind_echo_v, 32'hC0);
    // Asynchronous reset mid-cycle.
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 0, 32'd0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_outs("in_reset", 0, 32'd0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      drive(0, 32'd0, 0, 0, 1);
      @(negedge clk);
      check_outs("post_reset", 0, 32'd0, 0, 0, 1);
    end
    @(posedge clk);
    #1;
    drive(1, 32'h77, 0, 0, 1);
    @(negedge clk);
    check_outs("post_enq", 0, 32'd0, 0, 0, 1);
    @(posedge clk);
    #1;
    drive(0, 32'd0, 0, 0, 1);
    @(negedge clk);
    check_outs("post_fire", 1, 32'h77, 1, 0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outs("post_idle", 0, 32'd0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
